fmul_arbiter: RTL and testbench
===============================

// Module: fmul_arbiter
// PURPOSE
//  Shares one pipelined single-precision multiplier (fmul, registered output) among NREQ requesters.
//  Round-robin grant of at most one operand pair per cycle; tags each issue and routes each result back to its issuer.
//  Sits between the FPU issue ports (e.g. core FPU, vector helper) and the single fmul instance.
//  Multiplier is fully pipelined: one issue per cycle sustained, no structural stalls beyond arbitration.
// PARAMETERS
//  NREQ      2   number of requesters (2..4)
//  FMUL_LAT  1   cycles from fmul_x1/x2 driven to fmul_y valid (1 for the current fmul)
//  IDW       1   tag width, $clog2(NREQ) (min 1)
// PORTS
//  clk        in   1         clock, all state on posedge
//  rstn       in   1         reset, asynchronous, active-low
//  req_valid  in   NREQ      requester i presents an operand pair
//  req_ready  out  NREQ      one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_x1     in   NREQ*32   packed operand A, slice i = [32*i+31:32*i]
//  req_x2     in   NREQ*32   packed operand B, same packing
//  resp_valid out  NREQ      one-hot, 1-cycle pulse: resp_y belongs to requester i
//  resp_y     out  32        product returned from fmul (shared bus)
//  fmul_x1    out  32        operand A to fmul
//  fmul_x2    out  32        operand B to fmul
//  fmul_y     in   32        fmul registered result
//  busy       out  1         any issue in flight (tag pipe non-empty)
// BEHAVIOUR
//  Reset (rstn=0, async): rr_ptr=0, tag pipe valid bits all 0; resp_valid=0, busy=0.
//   Combinational outputs while in reset: req_ready=0, fmul_x1/x2=0.
//  Arbitration (combinational, same cycle):
//   - search from rr_ptr upward modulo NREQ; first i with req_valid[i] gets req_ready[i]=1
//   - req_ready depends on req_valid; requesters must not make valid depend on ready
//   - no valid requester -> req_ready=0, fmul_x1/x2 driven 0 (issue slot idle)
//  Pointer: on a grant to i, rr_ptr <= (i+1) mod NREQ at posedge; no grant -> rr_ptr holds.
//   - a persistent requester is granted at least once every NREQ cycles
//  Issue: granted slice of req_x1/req_x2 muxed onto fmul_x1/fmul_x2 in the grant cycle.
//  Tag pipe: FMUL_LAT-stage shift register of {vld,id[IDW-1:0]}; stage0 <= {grant_any, grant_id}.
//   - resp_valid[j] = last_stage.vld & (last_stage.id == j), combinational from registered tag
//   - resp_y = fmul_y, passed through; value undefined when resp_valid==0
//   - result for issue at cycle t appears at cycle t+FMUL_LAT; order = issue order
//  No response backpressure: requester must sample resp_y in the resp_valid cycle.
//  busy = OR of all tag-pipe vld bits.
//  Simultaneous events: issue and return in the same cycle are independent (pipe shifts every cycle).
//  Reset mid-operation: all in-flight tags dropped; no resp_valid for pre-reset issues,
//   even when fmul_y later changes. First post-reset grant goes to lowest-index valid requester.
//  Arithmetic: none inside the block; all FP behaviour (flush of zero exponent,
//   truncation, no rounding) belongs to fmul.
//  NREQ not a power of two: ids >= NREQ never generated; pointer wraps NREQ-1 -> 0.
// TESTING
//  1 single req0: x1=0x3FC00000 (1.5), x2=0x40000000 (2.0) at t -> req_ready[0]=1 at t; resp_valid=01, resp_y=0x40400000 at t+1.
//  2 req0,req1 valid continuously, NREQ=2, post-reset -> grants 0,1,0,1...; req1 pair 0x40000000*0x40400000 returns 0x40C00000 with resp_valid=10.
//  3 NREQ=4, only req2 and req3 valid, rr_ptr=0 -> grants 2,3,2,3; no grant to idle 0/1; busy=1 throughout.
//  4 FMUL_LAT=3 (stub fmul with 3 regs): back-to-back issues req0,req1,req0 -> responses at t+3,t+4,t+5, same order, correct ids.
//  5 rstn low for 1 cycle with 1 op in flight -> resp_valid stays 0 at expected return cycle; busy=0; next req1 issue returns normally.
//  6 no req_valid for 10 cycles -> req_ready=0, fmul_x1=fmul_x2=0, resp_valid=0, rr_ptr unchanged.

Source files
------------

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one pipelined fmul among NREQ requesters.
// Each issue is tagged with its requester id; the tag travels alongside the
// multiplier pipeline so the result is steered back to its issuer.
module fmul_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned FMUL_LAT = 1,
  parameter int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_y,
  output logic [31:0]          fmul_x1,
  output logic [31:0]          fmul_x2,
  input  logic [31:0]          fmul_y,
  output logic                 busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = IDW + 1;

  logic [IDW-1:0]                rr_ptr;
  logic                          grant_any;
  logic [IDW-1:0]                grant_id;
  logic [NREQ-1:0]               grant;
  logic [CW-1:0]                 cand;
  logic [FMUL_LAT-1:0]           tag_vld;
  logic [FMUL_LAT-1:0][IDW-1:0]  tag_id;

  // Round-robin search starting at rr_ptr; nothing is granted while in reset.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    cand      = '0;
    if (rstn) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rr_ptr} + CW'(k);
        if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
        for (int i = 0; i < NREQ; i++) begin
          if (!grant_any && (cand == CW'(i)) && req_valid[i]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(i);
            grant[i]  = 1'b1;
          end
        end
      end
    end
  end

  assign req_ready = grant;

  // Steer the granted operand pair onto the multiplier; idle slot drives zero.
  always_comb begin
    fmul_x1 = '0;
    fmul_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        fmul_x1 = req_x1[DW*i +: DW];
        fmul_x2 = req_x2[DW*i +: DW];
      end
    end
  end

  // Pointer moves just past the last winner; holds when the slot is idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Tag pipe mirrors the multiplier latency; shifts every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_id;
      for (int s = 1; s < FMUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  // Decode the returning tag into a one-hot response strobe.
  always_comb begin
    resp_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      resp_valid[j] = tag_vld[FMUL_LAT-1] && (tag_id[FMUL_LAT-1] == IDW'(j));
    end
  end

  assign resp_y = fmul_y;
  assign busy   = |tag_vld;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: random and directed issue traffic, a stub fmul with
// configurable latency, and a scoreboard matched by an independent monitor.
module tb_fmul_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 2;

  logic                clk  = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_x1 = '0;
  logic [NREQ*32-1:0]  req_x2 = '0;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_y;
  logic [31:0]         fmul_x1;
  logic [31:0]         fmul_x2;
  logic [31:0]         fmul_y;
  logic                busy;

  fmul_arbiter #(.NREQ(NREQ), .FMUL_LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2),
    .resp_valid(resp_valid), .resp_y(resp_y),
    .fmul_x1(fmul_x1), .fmul_x2(fmul_x2), .fmul_y(fmul_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple FP multiply: zero-exponent flush, truncated mantissa, no rounding.
  function automatic logic [31:0] fpm(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) return {s, 8'(e + 10'd1), m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  // Stub multiplier with LAT output registers.
  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= fpm(fmul_x1, fmul_x2);
    for (int s = 1; s < LAT; s++) fpipe[s] <= fpipe[s-1];
  end
  assign fmul_y = fpipe[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } exp_t;

  exp_t sb[$];
  int   mptr = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
  endfunction

  function automatic logic [NREQ*32-1:0] rnd_bus();
    logic [NREQ*32-1:0] r;
    for (int i = 0; i < NREQ; i++) r[32*i +: 32] = rnd_fp();
    return r;
  endfunction

  // One issue cycle: drive, predict the round-robin winner, check, enqueue.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] a,
                       input logic [NREQ*32-1:0] b, input int exp_id, input logic [31:0] exp_y);
    int              g;
    logic [NREQ-1:0] er;
    logic [31:0]     ex1, ex2;
    exp_t            e;
    @(negedge clk);
    req_valid = v;
    req_x1    = a;
    req_x2    = b;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (g < 0 && v[i]) g = i;
    end
    er = '0; ex1 = '0; ex2 = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ex1 = a[32*g +: 32];
      ex2 = b[32*g +: 32];
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("fmul_x1", 64'(fmul_x1), 64'(ex1));
    chk("fmul_x2", 64'(fmul_x2), 64'(ex2));
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    if (g >= 0) begin
      mptr  = (g + 1) % NREQ;
      e.due = cyc + LAT;
      e.id  = g;
      e.y   = (g == exp_id) ? exp_y : fpm(ex1, ex2);
      sb.push_back(e);
    end
  endtask

  // One cycle of reset with requests pending; all in-flight work is dropped.
  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = '1;
    req_x1    = rnd_bus();
    req_x2    = rnd_bus();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_fmul_x1", 64'(fmul_x1), 64'd0);
    chk("rst_fmul_x2", 64'(fmul_x2), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    sb.delete();
    mptr = 0;
    @(negedge clk);
    rstn      = 1'b1;
    req_valid = '0;
  endtask

  // Monitor: every response must match the oldest outstanding issue, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_spurious", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          chk("resp_valid", 64'(resp_valid), 64'(1) << e.id);
          chk("resp_y", 64'(resp_y), 64'(e.y));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("resp_missing", 64'(resp_valid), 64'(1) << e.id);
      end
    end
  end

  initial begin
    logic [NREQ*32-1:0] a, b;

    do_reset();

    // 1.5 * 2.0 from requester 0 right after reset
    a = rnd_bus(); b = rnd_bus();
    a[31:0] = 32'h3FC00000; b[31:0] = 32'h40000000;
    cycle(3'b001, a, b, 0, 32'h40400000);

    // requesters 0 and 1 both persistent: alternate grants; 2.0 * 3.0 from req1
    a = rnd_bus(); b = rnd_bus();
    a[63:32] = 32'h40000000; b[63:32] = 32'h40400000;
    cycle(3'b011, a, b, 1, 32'h40C00000);
    repeat (6) cycle(3'b011, rnd_bus(), rnd_bus(), -1, 32'd0);

    // all three persistent, then requesters 1 and 2 only
    repeat (6) cycle(3'b111, rnd_bus(), rnd_bus(), -1, 32'd0);
    repeat (5) cycle(3'b110, rnd_bus(), rnd_bus(), -1, 32'd0);

    repeat (300) cycle(3'($urandom), rnd_bus(), rnd_bus(), -1, 32'd0);

    // reset with one op in flight; then req1 issues normally
    cycle(3'b100, rnd_bus(), rnd_bus(), -1, 32'd0);
    do_reset();
    cycle(3'b110, rnd_bus(), rnd_bus(), -1, 32'd0);
    cycle(3'b000, rnd_bus(), rnd_bus(), -1, 32'd0);
    cycle(3'b000, rnd_bus(), rnd_bus(), -1, 32'd0);

    // idle slot for 10 cycles; pointer must be unchanged afterwards
    repeat (10) cycle(3'b000, rnd_bus(), rnd_bus(), -1, 32'd0);
    repeat (3) cycle(3'b111, rnd_bus(), rnd_bus(), -1, 32'd0);

    repeat (200) cycle(3'($urandom), rnd_bus(), rnd_bus(), -1, 32'd0);

    repeat (LAT + 2) cycle(3'b000, rnd_bus(), rnd_bus(), -1, 32'd0);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
